// File: rtl/coor_scan.sv
`default_nettype none
// ============================================================================
// Module      : coor_scan
// Description : Rectangle scan address generator. A start request in IDLE
//               captures a rectangle (origin x0/y0, size w/h) and a scan
//               order, then emits one linear address beat per accepted
//               handshake, walking the rectangle in row-major or
//               column-major order. Addresses are y*PITCH + x; only the
//               first beat uses a constant multiply, every later beat is
//               formed by adding to a previous address.
// Ports       : clk, rst         - clock, synchronous active-high reset
//               start, mode      - scan request and order (0 row, 1 column)
//               x0, y0, w, h     - rectangle origin and size
//               busy             - high while scanning
//               addr_valid/ready - beat handshake
//               addr, cur_x/y    - linear address and coordinates of beat
//               last             - beat is the final one of the rectangle
//               done, err        - one-cycle completion / rejection pulses
// Revision    : 1.0 - initial release
// ============================================================================
module coor_scan #(
  parameter int X_W    = 7,
  parameter int Y_W    = 4,
  parameter int PITCH  = 79,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic [X_W-1:0]    x0,
  input  logic [Y_W-1:0]    y0,
  input  logic [X_W:0]      w,
  input  logic [Y_W:0]      h,
  output logic              busy,
  output logic              addr_valid,
  input  logic              addr_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [X_W-1:0]    cur_x,
  output logic [Y_W-1:0]    cur_y,
  output logic              last,
  output logic              done,
  output logic              err
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] C_PITCH    = ADDR_W'(PITCH);
  localparam logic [31:0]       C_PITCH_32 = 32'(PITCH);
  localparam logic [31:0]       C_ROWS_32  = 32'(1) << Y_W;

  // Registered state
  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic [X_W-1:0]    x0_q, x0_d;
  logic [Y_W-1:0]    y0_q, y0_d;
  logic [X_W-1:0]    xend_q, xend_d;
  logic [Y_W-1:0]    yend_q, yend_d;
  // Address of the first beat of the current row (row-major) or of the
  // current column (column-major); wraps jump relative to it, so the
  // (h-1)*PITCH rewind never needs a multiplier.
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [X_W-1:0]    cur_x_q, cur_x_d;
  logic [Y_W-1:0]    cur_y_q, cur_y_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;

  // Request qualification
  logic [31:0]       sum_x, sum_y;
  logic              req_err, req_empty;
  logic [ADDR_W-1:0] first_addr;
  logic [X_W-1:0]    req_xend;
  logic [Y_W-1:0]    req_yend;

  // Next-beat computation
  logic              xfer;
  logic [X_W-1:0]    nx;
  logic [Y_W-1:0]    ny;
  logic [ADDR_W-1:0] naddr, nbase;
  logic              nlast;

  always_comb begin
    sum_x      = 32'(x0) + 32'(w);
    sum_y      = 32'(y0) + 32'(h);
    req_err    = (sum_x > C_PITCH_32) || (sum_y > C_ROWS_32);
    req_empty  = (w == '0) || (h == '0);
    first_addr = (ADDR_W'(y0) * C_PITCH) + ADDR_W'(x0);
    // Only used when w,h >= 1, so the subtraction never underflows.
    req_xend   = X_W'(sum_x - 32'd1);
    req_yend   = Y_W'(sum_y - 32'd1);
  end

  always_comb begin
    xfer  = valid_q && addr_ready;
    nx    = cur_x_q;
    ny    = cur_y_q;
    naddr = addr_q;
    nbase = base_q;
    if (!mode_q) begin
      if (cur_x_q == xend_q) begin
        nx    = x0_q;
        ny    = cur_y_q + Y_W'(1);
        naddr = base_q + C_PITCH;
        nbase = base_q + C_PITCH;
      end else begin
        nx    = cur_x_q + X_W'(1);
        naddr = addr_q + ADDR_W'(1);
      end
    end else begin
      if (cur_y_q == yend_q) begin
        ny    = y0_q;
        nx    = cur_x_q + X_W'(1);
        naddr = base_q + ADDR_W'(1);
        nbase = base_q + ADDR_W'(1);
      end else begin
        ny    = cur_y_q + Y_W'(1);
        naddr = addr_q + C_PITCH;
      end
    end
    nlast = (nx == xend_q) && (ny == yend_q);
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    x0_d    = x0_q;
    y0_d    = y0_q;
    xend_d  = xend_q;
    yend_d  = yend_q;
    base_d  = base_q;
    addr_d  = addr_q;
    cur_x_d = cur_x_q;
    cur_y_d = cur_y_q;
    valid_d = valid_q;
    last_d  = last_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (req_err) begin
            err_d = 1'b1;
          end else if (req_empty) begin
            done_d = 1'b1;
          end else begin
            state_d = SCAN;
            mode_d  = mode;
            x0_d    = x0;
            y0_d    = y0;
            xend_d  = req_xend;
            yend_d  = req_yend;
            base_d  = first_addr;
            addr_d  = first_addr;
            cur_x_d = x0;
            cur_y_d = y0;
            valid_d = 1'b1;
            last_d  = (w == (X_W+1)'(1)) && (h == (Y_W+1)'(1));
          end
        end
      end
      SCAN: begin
        if (xfer) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cur_x_d = nx;
            cur_y_d = ny;
            addr_d  = naddr;
            base_d  = nbase;
            last_d  = nlast;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase

    busy_d = (state_d == SCAN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 1'b0;
      x0_q    <= '0;
      y0_q    <= '0;
      xend_q  <= '0;
      yend_q  <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      xend_q  <= xend_d;
      yend_q  <= yend_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      cur_x_q <= cur_x_d;
      cur_y_q <= cur_y_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      done_q  <= done_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign busy       = busy_q;
  assign addr_valid = valid_q;
  assign addr       = addr_q;
  assign cur_x      = cur_x_q;
  assign cur_y      = cur_y_q;
  assign last       = last_q;
  assign done       = done_q;
  assign err        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_coor_scan.sv
`default_nettype none
// ============================================================================
// Module      : tb_coor_scan
// Description : Directed self-checking bench for coor_scan with default
//               parameters (X_W=7, Y_W=4, PITCH=79, ADDR_W=11). Inputs are
//               driven 1 time unit after the rising edge and outputs are
//               sampled at the same point.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_coor_scan;

  localparam int X_W    = 7;
  localparam int Y_W    = 4;
  localparam int PITCH  = 79;
  localparam int ADDR_W = 11;

  logic              clk;
  logic              rst;
  logic              start;
  logic              mode;
  logic [X_W-1:0]    x0;
  logic [Y_W-1:0]    y0;
  logic [X_W:0]      w;
  logic [Y_W:0]      h;
  logic              busy;
  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] addr;
  logic [X_W-1:0]    cur_x;
  logic [Y_W-1:0]    cur_y;
  logic              last;
  logic              done;
  logic              err;

  int n_checks = 0;
  int n_errors = 0;

  coor_scan #(
    .X_W    (X_W),
    .Y_W    (Y_W),
    .PITCH  (PITCH),
    .ADDR_W (ADDR_W)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .x0         (x0),
    .y0         (y0),
    .w          (w),
    .h          (h),
    .busy       (busy),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr       (addr),
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .last       (last),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one cycle; on return the first response is visible.
  task automatic do_start(input bit m, input int sx, input int sy,
                          input int sw, input int sh);
    mode  = m;
    x0    = X_W'(sx);
    y0    = Y_W'(sy);
    w     = (X_W+1)'(sw);
    h     = (Y_W+1)'(sh);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Check the beat currently presented, then advance one cycle.
  task automatic beat(input string tag, input int a, input int x,
                      input int y, input bit l);
    check({tag, " valid"}, 32'(addr_valid), 32'd1);
    check({tag, " busy"},  32'(busy),       32'd1);
    check({tag, " addr"},  32'(addr),       32'(a));
    check({tag, " x"},     32'(cur_x),      32'(x));
    check({tag, " y"},     32'(cur_y),      32'(y));
    check({tag, " last"},  32'(last),       32'(l));
    check({tag, " done"},  32'(done),       32'd0);
    step();
  endtask

  // Expect the done pulse on the IDLE-return cycle, then its de-assertion.
  task automatic finish_scan(input string tag);
    check({tag, " end valid"}, 32'(addr_valid), 32'd0);
    check({tag, " end busy"},  32'(busy),       32'd0);
    check({tag, " end done"},  32'(done),       32'd1);
    check({tag, " end err"},   32'(err),        32'd0);
    step();
    check({tag, " done pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b1;
    mode       = 1'b0;
    x0         = 7'd3;
    y0         = 4'd2;
    w          = 8'd2;
    h          = 5'd2;
    addr_ready = 1'b1;

    // Reset overrides a concurrent start.
    step();
    step();
    check("rst valid", 32'(addr_valid), 32'd0);
    check("rst busy",  32'(busy),       32'd0);
    check("rst addr",  32'(addr),       32'd0);
    check("rst x",     32'(cur_x),      32'd0);
    check("rst y",     32'(cur_y),      32'd0);
    check("rst last",  32'(last),       32'd0);
    check("rst done",  32'(done),       32'd0);
    check("rst err",   32'(err),        32'd0);
    start = 1'b0;
    rst   = 1'b0;
    step();
    check("idle valid", 32'(addr_valid), 32'd0);

    // Row-major 2x2 at (3,2).
    do_start(1'b0, 3, 2, 2, 2);
    beat("row b0", 161, 3, 2, 1'b0);
    beat("row b1", 162, 4, 2, 1'b0);
    beat("row b2", 240, 3, 3, 1'b0);
    beat("row b3", 241, 4, 3, 1'b1);
    finish_scan("row");

    // Column-major, same rectangle.
    do_start(1'b1, 3, 2, 2, 2);
    beat("col b0", 161, 3, 2, 1'b0);
    beat("col b1", 240, 3, 3, 1'b0);
    beat("col b2", 162, 4, 2, 1'b0);
    beat("col b3", 241, 4, 3, 1'b1);
    finish_scan("col");

    // Backpressure on beat 1: address held for 4 cycles in total.
    do_start(1'b0, 3, 2, 2, 2);
    beat("bp b0", 161, 3, 2, 1'b0);
    addr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp hold valid", 32'(addr_valid), 32'd1);
      check("bp hold addr",  32'(addr),       32'd162);
      check("bp hold x",     32'(cur_x),      32'd4);
      check("bp hold last",  32'(last),       32'd0);
      step();
    end
    addr_ready = 1'b1;
    beat("bp b1", 162, 4, 2, 1'b0);
    beat("bp b2", 240, 3, 3, 1'b0);
    beat("bp b3", 241, 4, 3, 1'b1);
    finish_scan("bp");

    // Empty rectangle: done without beats.
    do_start(1'b0, 5, 5, 0, 3);
    check("empty done",  32'(done),       32'd1);
    check("empty err",   32'(err),        32'd0);
    check("empty valid", 32'(addr_valid), 32'd0);
    check("empty busy",  32'(busy),       32'd0);
    step();
    check("empty done pulse", 32'(done),       32'd0);
    check("empty valid2",     32'(addr_valid), 32'd0);

    // Out of range in x (78+2 > 79).
    do_start(1'b0, 78, 0, 2, 1);
    check("xerr err",   32'(err),        32'd1);
    check("xerr done",  32'(done),       32'd0);
    check("xerr valid", 32'(addr_valid), 32'd0);
    step();
    check("xerr err pulse", 32'(err),        32'd0);
    check("xerr valid2",    32'(addr_valid), 32'd0);

    // Out of range in y with w=0: err wins over the empty check.
    do_start(1'b0, 0, 15, 0, 2);
    check("prio err",   32'(err),        32'd1);
    check("prio done",  32'(done),       32'd0);
    check("prio valid", 32'(addr_valid), 32'd0);
    step();

    // Exact fit at the boundary is accepted (x0+w = PITCH, y0+h = 16).
    do_start(1'b0, 78, 15, 1, 1);
    beat("edge b0", 1263, 78, 15, 1'b1);
    finish_scan("edge");

    // Reset mid-scan on beat 2, then an immediate new single-beat request.
    do_start(1'b0, 3, 2, 2, 2);
    beat("rs b0", 161, 3, 2, 1'b0);
    beat("rs b1", 162, 4, 2, 1'b0);
    check("rs b2 addr", 32'(addr), 32'd240);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rs valid", 32'(addr_valid), 32'd0);
    check("rs busy",  32'(busy),       32'd0);
    check("rs addr",  32'(addr),       32'd0);
    check("rs x",     32'(cur_x),      32'd0);
    check("rs y",     32'(cur_y),      32'd0);
    check("rs last",  32'(last),       32'd0);
    check("rs done",  32'(done),       32'd0);
    check("rs err",   32'(err),        32'd0);
    do_start(1'b0, 0, 15, 1, 1);
    beat("one b0", 1185, 0, 15, 1'b1);
    finish_scan("one");

    // Start pulsed while busy must be ignored and not remembered.
    do_start(1'b0, 3, 2, 2, 2);
    beat("ign b0", 161, 3, 2, 1'b0);
    mode  = 1'b1;
    x0    = 7'd0;
    y0    = 4'd0;
    w     = 8'd1;
    h     = 5'd1;
    start = 1'b1;
    beat("ign b1", 162, 4, 2, 1'b0);
    beat("ign b2", 240, 3, 3, 1'b0);
    start = 1'b0;
    beat("ign b3", 241, 4, 3, 1'b1);
    finish_scan("ign");
    for (int i = 0; i < 3; i++) begin
      check("ign no relatch", 32'(addr_valid), 32'd0);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/coor_scan.md
COOR_SCAN -- requirements
Module: coor_scan

Interface
REQ-001 Parameter X_W, default 7, column coordinate width.
REQ-002 Parameter Y_W, default 4, row coordinate width.
REQ-003 Parameter PITCH, default 79, pixels per row (linear stride).
REQ-004 Parameter ADDR_W, default 11, linear address width; SHALL satisfy 2^ADDR_W >= PITCH*2^Y_W.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 start  input  1  request a rectangle scan; sampled only in IDLE.
REQ-008 mode  input  1  0 = row-major, 1 = column-major; captured with start.
REQ-009 x0 / y0  input  X_W / Y_W  rectangle origin; captured with start.
REQ-010 w / h  input  X_W+1 / Y_W+1  rectangle width / height; captured with start.
REQ-011 busy  output  1  high in SCAN.
REQ-012 addr_valid  output  1  addr beat valid.
REQ-013 addr_ready  input  1  downstream accepts beat.
REQ-014 addr  output  ADDR_W  linear address = y*PITCH + x.
REQ-015 cur_x / cur_y  output  X_W / Y_W  coordinates of current beat.
REQ-016 last  output  1  current beat is final beat of rectangle.
REQ-017 done  output  1  one-cycle pulse, scan finished.
REQ-018 err  output  1  one-cycle pulse, request rejected.

Function
REQ-019 States IDLE, SCAN; done/err SHALL be registered pulses issued on the IDLE-return cycle.
REQ-020 IDLE + start: if w==0 or h==0 -> done pulse next cycle, no beats, stay IDLE.
REQ-021 IDLE + start: if x0+w > PITCH or y0+h > 2^Y_W -> err pulse next cycle, no beats, stay IDLE; err takes priority over the REQ-020 check.
REQ-022 Otherwise -> SCAN; first beat (x0,y0) SHALL present addr_valid=1 on the cycle after start (latency 1), addr = y0*PITCH + x0.
REQ-023 Beat transfers when addr_valid && addr_ready; addr, cur_x, cur_y, last SHALL hold stable while addr_valid && !addr_ready.
REQ-024 Row-major step: x+1, addr+1; at x = x0+w-1: x<-x0, y+1, addr += PITCH-(w-1).
REQ-025 Column-major step: y+1, addr+PITCH; at y = y0+h-1: y<-y0, x+1, addr -= (h-1)*PITCH then +1.
REQ-026 Addresses after the first SHALL be formed incrementally (adders only); first-beat product y0*PITCH is a constant multiply.
REQ-027 last=1 only with the beat at (x0+w-1, y0+h-1); transfer of that beat -> IDLE, addr_valid=0 and done=1 next cycle.
REQ-028 addr_valid SHALL be continuous in SCAN (no bubbles); throughput 1 beat/cycle with addr_ready held high.
REQ-029 start while busy SHALL be ignored; no latching for later.
REQ-030 w*h = 1: single beat with last=1.
REQ-031 All arithmetic unsigned, ADDR_W bits; under REQ-004 no wrap-around occurs.

Reset
REQ-032 rst SHALL force IDLE and busy, addr_valid, addr, cur_x, cur_y, last, done, err = 0 on the next edge, overriding all other inputs including start.
REQ-033 rst mid-scan SHALL abandon the scan without done pulse; a start on the first cycle after rst deasserts SHALL be accepted.

Verification
REQ-034 PITCH=79, mode=0, x0=3,y0=2,w=2,h=2, ready=1 -> addr 161,162,240,241 on consecutive cycles, last only on 241, done one cycle later.
REQ-035 Same rectangle, mode=1 -> addr 161,240,162,241; cur (3,2),(3,3),(4,2),(4,3).
REQ-036 Backpressure: ready=0 for 3 cycles on beat 2 of REQ-034 -> addr 162 held 4 cycles, no beat lost or duplicated.
REQ-037 start with w=0 -> done next cycle, addr_valid never high; start with x0=78,w=2 -> err next cycle, no beats.
REQ-038 rst asserted during beat 3 of REQ-034 -> all outputs 0 next cycle, no done; new start x0=0,y0=15,w=1,h=1 -> single beat addr 1185, last=1.
REQ-039 start pulsed while busy -> ignored; beat sequence and count identical to REQ-034.
